// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial unsigned adder that uses an external full adder.
// A start in IDLE captures both operands and the carry-in. Each RUN cycle then
// presents one operand bit pair and the running carry to the full adder, LSB
// first. The returned sum bit is collected, and the returned carry is kept for
// the next bit. After WIDTH bits the result is latched into sum_out/cout_out,
// and done pulses for the one DONE cycle.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one full-adder evaluation per clock, LSB first
// DONE  | result latched, done pulse; back to IDLE next edge
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [WIDTH-1:0] sum_sh_d;
    logic [CW-1:0]    cnt_d;
    logic             in_run;

    // Next values of the datapath for one RUN step. The sum enters at the MSB,
    // so after WIDTH shifts the first (LSB) result bit sits at bit 0.
    always_comb begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
    end

    // Full-adder inputs are combinational from the operand LSBs and the carry.
    // They are forced to 0 outside RUN, so the external adder sees quiet inputs.
    assign in_run = (state_q == RUN);
    assign fa_a   = in_run & a_sh_q[0];
    assign fa_b   = in_run & b_sh_q[0];
    assign fa_cin = in_run & carry_q;

    // Sequencer: the state, the datapath registers and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q   <= a_in;
                        b_sh_q   <= b_in;
                        sum_sh_q <= '0;
                        carry_q  <= cin_in;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_d;
                    b_sh_q   <= b_sh_d;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= fa_cout;
                    cnt_q    <= cnt_d;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= sum_sh_d;
                        cout_q  <= fa_cout;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high through this cycle and drops with the return to IDLE.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum_out  = sum_q;
    assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: an external full adder, directed and random stimulus,
// and a scoreboard of accepted additions checked by a decoupled monitor.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;
    logic         busy, done, cout_out;
    logic [W-1:0] sum_out;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
        .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out)
    );

    // External full adder.
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        int           acc;
    } txn_t;

    txn_t         sb[$];
    int           cyc = 0;
    int           busy_until = 0;
    logic [W:0]   last_res = '0;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Acceptance model: a start is taken at an edge only if the previous one
    // has fully finished (WIDTH bits, one DONE cycle, back in IDLE).
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst && start && cyc >= busy_until) begin
                txn_t t;
                t.a = a_in; t.b = b_in; t.c = cin_in; t.acc = cyc;
                sb.push_back(t);
                busy_until = cyc + W + 2;
            end
        end
    end

    // Monitor: compares the DUT against the head of the scoreboard on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("idle_busy", 64'(busy), 64'd0);
                chk("idle_done", 64'(done), 64'd0);
                chk("idle_fa", {61'd0, fa_a, fa_b, fa_cin}, 64'd0);
                chk("idle_hold", {55'd0, cout_out, sum_out}, 64'(last_res));
            end else begin
                txn_t t;
                int k;
                t = sb[0];
                k = cyc - t.acc;
                if (k < W) begin
                    longint unsigned m, carry;
                    m = (64'd1 << k) - 1;
                    carry = ((64'(t.a) & m) + (64'(t.b) & m) + 64'(t.c)) >> k;
                    chk("run_fa_a", 64'(fa_a), 64'(t.a[k]));
                    chk("run_fa_b", 64'(fa_b), 64'(t.b[k]));
                    chk("run_fa_cin", 64'(fa_cin), carry);
                    chk("run_busy", 64'(busy), 64'd1);
                    chk("run_done", 64'(done), 64'd0);
                    chk("run_hold", {55'd0, cout_out, sum_out}, 64'(last_res));
                end else begin
                    logic [W:0] exp_res;
                    exp_res = (W+1)'(64'(t.a) + 64'(t.b) + 64'(t.c));
                    chk("done_pulse", 64'(done), 64'd1);
                    chk("done_busy", 64'(busy), 64'd1);
                    chk("done_fa", {61'd0, fa_a, fa_b, fa_cin}, 64'd0);
                    chk("result", {55'd0, cout_out, sum_out}, 64'(exp_res));
                    last_res = exp_res;
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Drive inputs for the next rising edge and return just after it.
    task automatic tick(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start = s; a_in = a; b_in = b; cin_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        tick(1'b1, a, b, c);
        idle(W + 1);
    endtask

    // Reset pulse asserted mid-cycle, away from both clock edges.
    task automatic pulse_reset();
        start = 1'b0;
        #1;
        rst = 1'b1;
        sb.delete();
        busy_until = 0;
        last_res = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", {55'd0, cout_out, sum_out}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", {55'd0, cout_out, sum_out}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        op(8'hFF, 8'h01, 1'b0);
        op(8'hA5, 8'h5A, 1'b1);
        op(8'h3C, 8'h0F, 1'b0);

        // start during RUN and during DONE, then a new start right after DONE
        tick(1'b1, 8'h3C, 8'h0F, 1'b1);
        for (int i = 1; i <= W + 1; i++)
            tick((i == 4) || (i == W + 1), 8'h11, 8'h11, 1'b1);
        op(8'h01, 8'h01, 1'b0);

        // abort at RUN bit 4, then a clean operation
        tick(1'b1, 8'hF0, 8'h0F, 1'b1);
        start = 1'b0;
        repeat (4) @(posedge clk);
        pulse_reset();
        op(8'h7F, 8'h01, 1'b1);

        // random traffic, including starts while busy and occasional aborts
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else tick($urandom_range(0, 2) == 0, W'($urandom), W'($urandom), 1'($urandom));
        end
        idle(W + 3);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
